// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls, EX redirects,
// data-memory freezes with a halting timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic mem_wait;
  logic load_use;
  logic is_halted;
  logic redirect_taken;

  assign mem_wait = dmem_req & ~dmem_ready;
  // x0 never carries a hazard, so ex_rd == 0 is excluded up front.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));
  // Reset forces RUN decode even if the state register still holds HALT.
  assign is_halted = (state == HALT) & ~reset;

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_write    = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_write   = 1'b1;
    mem_wb_write   = 1'b1;
    redirect_taken = 1'b0;
    if (is_halted || mem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (ex_redirect) begin
      // Redirect beats load-use: the stalled ID instruction is discarded anyway.
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      if (!pc_write && state != HALT && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_taken && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign halted_o    = is_halted;
  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a decode vector table plus hand-written
// multi-cycle sequences for stalls, freezes, timeout, and counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Stage-control bit order: pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_w
  localparam logic [6:0] S_NORM  = 7'b1101011;
  localparam logic [6:0] S_FRZ   = 7'b0000000;
  localparam logic [6:0] S_REDIR = 7'b1111111;
  localparam logic [6:0] S_LU    = 7'b0001111;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             dmem_req, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic             ex_mem_write, mem_wb_write, halted_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .halted_o(halted_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [6:0] stage_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
            ex_mem_write, mem_wb_write};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic redir, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_redirect = redir;
    dmem_req = req; dmem_ready = rdy;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One reset cycle; returns at the negedge after the reset edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
    check("reset_decode", 32'(stage_vec()), 32'(S_LU));
    check("reset_halted", 32'(halted_o), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_state", 32'(state_o), 0);
    check("post_reset_stall", 32'(stall_cnt_o), 0);
    check("post_reset_flush", 32'(flush_cnt_o), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("init_state", 32'(state_o), 0);
    check("init_halted", 32'(halted_o), 0);
    check("init_stall", 32'(stall_cnt_o), 0);
    check("init_flush", 32'(flush_cnt_o), 0);

    vecs[0]  = '{"lu_rs1",        5, 0, 1, 0, 5, 1, 0, 0, 0, S_LU};
    vecs[1]  = '{"x0_no_stall",   0, 0, 1, 1, 0, 1, 0, 0, 0, S_NORM};
    vecs[2]  = '{"lu_rs2",        1, 7, 1, 1, 7, 1, 0, 0, 0, S_LU};
    vecs[3]  = '{"rs2_unused",    1, 7, 1, 0, 7, 1, 0, 0, 0, S_NORM};
    vecs[4]  = '{"not_load",      5, 0, 1, 0, 5, 0, 0, 0, 0, S_NORM};
    vecs[5]  = '{"redir_over_lu", 5, 0, 1, 0, 5, 1, 1, 0, 0, S_REDIR};
    vecs[6]  = '{"wait_over_rd",  5, 0, 1, 0, 5, 1, 1, 1, 0, S_FRZ};
    vecs[7]  = '{"ready_lu",      5, 0, 1, 0, 5, 1, 0, 1, 1, S_LU};
    vecs[8]  = '{"redir_only",    3, 4, 1, 1, 9, 0, 1, 0, 0, S_REDIR};
    vecs[9]  = '{"wait_only",     3, 4, 1, 1, 9, 0, 0, 1, 0, S_FRZ};
    vecs[10] = '{"req_dropped",   3, 4, 1, 1, 9, 0, 0, 0, 1, S_NORM};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].mr, vecs[i].redir, vecs[i].req, vecs[i].rdy);
      check(vecs[i].name, 32'(stage_vec()), 32'(vecs[i].exp));
    end

    // Load-use stall for one cycle, then the x0 variant.
    do_reset();
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
    check("seq1_lu", 32'(stage_vec()), 32'(S_LU));
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    check("seq1_x0", 32'(stage_vec()), 32'(S_NORM));
    check("seq1_stall", 32'(stall_cnt_o), 1);
    @(negedge clk);
    idle();
    check("seq1_stall_x0", 32'(stall_cnt_o), 1);

    // Redirect together with load-use.
    do_reset();
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
    check("seq2_out", 32'(stage_vec()), 32'(S_REDIR));
    @(negedge clk);
    idle();
    check("seq2_flush", 32'(flush_cnt_o), 1);
    check("seq2_stall", 32'(stall_cnt_o), 0);

    // Three wait cycles then ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("seq3_frz", 32'(stage_vec()), 32'(S_FRZ));
      check("seq3_state", 32'(state_o), (i == 0) ? 0 : 1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("seq3_ready_out", 32'(stage_vec()), 32'(S_NORM));
    check("seq3_ready_state", 32'(state_o), 1);
    @(negedge clk);
    idle();
    check("seq3_back_run", 32'(state_o), 0);
    check("seq3_stall", 32'(stall_cnt_o), 3);

    // Timeout into HALT, then recovery by reset.
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("seq4_frz", 32'(stage_vec()), 32'(S_FRZ));
      check("seq4_state", 32'(state_o), (i == 0) ? 0 : 1);
      check("seq4_not_halted", 32'(halted_o), 0);
      @(negedge clk);
    end
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
    check("seq4_halt_state", 32'(state_o), 2);
    check("seq4_halted", 32'(halted_o), 1);
    check("seq4_halt_out", 32'(stage_vec()), 32'(S_FRZ));
    check("seq4_stall", 32'(stall_cnt_o), TIMEOUT);
    @(negedge clk);
    #2;
    check("seq4_stall_hold", 32'(stall_cnt_o), TIMEOUT);
    check("seq4_flush_hold", 32'(flush_cnt_o), 0);
    check("seq4_still_halt", 32'(state_o), 2);
    do_reset();
    check("seq4_reset_halted", 32'(halted_o), 0);

    // Redirect held through a freeze, acted on at the ready cycle.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("seq5_frz", 32'(stage_vec()), 32'(S_FRZ));
      check("seq5_flush_wait", 32'(flush_cnt_o), 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("seq5_ready_out", 32'(stage_vec()), 32'(S_REDIR));
    @(negedge clk);
    idle();
    check("seq5_flush", 32'(flush_cnt_o), 1);
    check("seq5_stall", 32'(stall_cnt_o), 2);

    // Stall counter saturation.
    do_reset();
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
    repeat (14) @(negedge clk);
    #1;
    check("seq6_stall_14", 32'(stall_cnt_o), 14);
    @(negedge clk);
    #1;
    check("seq6_stall_15", 32'(stall_cnt_o), 15);
    repeat (5) @(negedge clk);
    #1;
    check("seq6_stall_sat", 32'(stall_cnt_o), 15);
    check("seq6_out", 32'(stage_vec()), 32'(S_LU));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
